// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A-B, LSB first, through one full-subtractor cell
// with a registered borrow; result, borrow and zero flags publish with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
  // sd keeps only the bits still needed; the oldest bit falls off as each new one enters
  logic [WIDTH-1:1] sd_q, sd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bflop_q, bflop_d, borrow_q, borrow_d, zero_q, zero_d;
  logic             x, y, d, bout;
  logic [WIDTH-1:0] res;
  always_comb begin
    x = sa_q[0];
    y = sb_q[0];
    d = x ^ y ^ bflop_q;
    bout = (~x & y) | (~(x ^ y) & bflop_q);
    res = {d, sd_q};
    state_d = state_q;
    sa_d = sa_q;
    sb_d = sb_q;
    sd_d = sd_q;
    cnt_d = cnt_q;
    bflop_d = bflop_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        sa_d = a;
        sb_d = b;
        sd_d = '0;
        cnt_d = '0;
        bflop_d = 1'b0;
      end
      SHIFT: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sd_d = res[WIDTH-1:1];
        bflop_d = bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d = res;
          borrow_d = bout;
          zero_d = (res == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      sd_q <= '0;
      cnt_q <= '0;
      bflop_q <= 1'b0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      sd_q <= sd_d;
      cnt_q <= cnt_d;
      bflop_q <= bflop_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      zero_q <= zero_d;
    end
  end
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign borrow = borrow_q;
  assign zero = zero_q;
endmodule
